// File: rtl/ovi_vector_responder_if.sv
// ovi_vector_responder_if: OVI issue/completion bundle plus load/store petition and response lines
interface ovi_vector_responder_if #(
  parameter int INSTR_W = 32,
  parameter int OPND_W  = 32,
  parameter int VL_W    = 14
);
  logic               issue_valid;
  logic [INSTR_W-1:0] issue_instr;
  logic [OPND_W-1:0]  issue_opnd;
  logic [VL_W-1:0]    issue_vl;
  logic [2:0]         issue_sew;
  logic               issue_wb;
  logic               completed_valid;
  logic [OPND_W-1:0]  completed_data;
  logic               completed_illegal;
  logic               completed_timeout;
  logic               ls_load_valid;
  logic               ls_store_valid;
  logic [31:0]        ls_store_data;
  logic               mem_ready;
  logic               resp_load_valid;
  logic [31:0]        resp_load_data;
  logic               busy;
  logic               proto_err;
  modport master (
    output issue_valid, issue_instr, issue_opnd, issue_vl, issue_sew, issue_wb,
    output mem_ready, resp_load_valid, resp_load_data,
    input  completed_valid, completed_data, completed_illegal, completed_timeout,
    input  ls_load_valid, ls_store_valid, ls_store_data, busy, proto_err
  );
  modport slave (
    input  issue_valid, issue_instr, issue_opnd, issue_vl, issue_sew, issue_wb,
    input  mem_ready, resp_load_valid, resp_load_data,
    output completed_valid, completed_data, completed_illegal, completed_timeout,
    output ls_load_valid, ls_store_valid, ls_store_data, busy, proto_err
  );
endinterface

// File: rtl/ovi_vector_responder.sv
// ovi_vector_responder: abstract VPU end of the OVI link; completes issued ops and drives load/store petitions
module ovi_vector_responder #(
  parameter int INSTR_W   = 32,
  parameter int OPND_W    = 32,
  parameter int VL_W      = 14,
  parameter int ARITH_LAT = 4,
  parameter int TIMEOUT   = 64
) (
  input logic CLK,
  input logic RST,
  ovi_vector_responder_if.slave bus
);
  localparam logic [6:0] OP_ARITH = 7'b1010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000111;
  localparam logic [6:0] OP_STORE = 7'b0100111;
  localparam int LW = $clog2(ARITH_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ARITH, LS_REQ, LS_WAIT, DONE} state_t;
  state_t            state;
  logic [6:0]        op;
  logic [OPND_W-1:0] opnd;
  logic [OPND_W-1:0] acc;
  logic [VL_W-1:0]   vl;
  logic [VL_W-1:0]   elem_cnt;
  logic [VL_W-1:0]   idx;
  logic              wb;
  logic              timed_out;
  logic [LW-1:0]     lat_cnt;
  logic [TW-1:0]     to_cnt;
  logic [6:0]        issue_op;
  logic              pet_gap;
  assign issue_op = bus.issue_instr[6:0];
  // a petition register still high means the previous cycle petitioned; skip one cycle
  assign pet_gap = bus.ls_load_valid | bus.ls_store_valid;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state                 <= IDLE;
      op                    <= '0;
      opnd                  <= '0;
      acc                   <= '0;
      vl                    <= '0;
      elem_cnt              <= '0;
      idx                   <= '0;
      wb                    <= 1'b0;
      timed_out             <= 1'b0;
      lat_cnt               <= '0;
      to_cnt                <= '0;
      bus.completed_valid   <= 1'b0;
      bus.completed_data    <= '0;
      bus.completed_illegal <= 1'b0;
      bus.completed_timeout <= 1'b0;
      bus.ls_load_valid     <= 1'b0;
      bus.ls_store_valid    <= 1'b0;
      bus.ls_store_data     <= '0;
      bus.busy              <= 1'b0;
      bus.proto_err         <= 1'b0;
    end else begin
      bus.completed_valid   <= 1'b0;
      bus.completed_data    <= '0;
      bus.completed_illegal <= 1'b0;
      bus.completed_timeout <= 1'b0;
      bus.ls_load_valid     <= 1'b0;
      bus.ls_store_valid    <= 1'b0;
      if (bus.issue_valid && state != IDLE) bus.proto_err <= 1'b1;
      case (state)
        IDLE: if (bus.issue_valid) begin
          op        <= issue_op;
          opnd      <= bus.issue_opnd;
          vl        <= bus.issue_vl;
          wb        <= bus.issue_wb;
          elem_cnt  <= bus.issue_vl;
          idx       <= '0;
          acc       <= '0;
          timed_out <= 1'b0;
          lat_cnt   <= LW'(ARITH_LAT - 1);
          bus.busy  <= 1'b1;
          state     <= issue_op == OP_ARITH ? (ARITH_LAT == 1 ? DONE : ARITH) :
                       (issue_op == OP_LOAD || issue_op == OP_STORE) && bus.issue_vl != '0 ? LS_REQ : DONE;
        end
        ARITH: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt <= LW'(1)) state <= DONE;
        end
        LS_REQ: if (bus.mem_ready && !pet_gap) begin
          if (op == OP_LOAD) begin
            bus.ls_load_valid <= 1'b1;
            to_cnt            <= '0;
            state             <= LS_WAIT;
          end else begin
            bus.ls_store_valid <= 1'b1;
            bus.ls_store_data  <= opnd[31:0] + 32'(idx);
            idx                <= idx + 1'b1;
            elem_cnt           <= elem_cnt - 1'b1;
            if (elem_cnt == VL_W'(1)) state <= DONE;
          end
        end
        LS_WAIT: if (bus.resp_load_valid) begin
          acc      <= acc + OPND_W'(bus.resp_load_data);
          elem_cnt <= elem_cnt - 1'b1;
          state    <= elem_cnt == VL_W'(1) ? DONE : LS_REQ;
        end else if (to_cnt == TW'(TIMEOUT - 1)) begin
          timed_out <= 1'b1;
          state     <= DONE;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
        DONE: begin
          bus.completed_valid   <= 1'b1;
          bus.completed_data    <= op == OP_ARITH ? (wb ? opnd + OPND_W'(vl) : '0) : op == OP_LOAD ? acc : '0;
          bus.completed_illegal <= op != OP_ARITH && op != OP_LOAD && op != OP_STORE;
          bus.completed_timeout <= timed_out;
          bus.busy              <= 1'b0;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
